// File: rtl/deck_shuffler_if.sv
// deck_shuffler_if
//   Card stream handshake between the deck shuffler and the setup dealer.
//   master (shuffler): drives card_out, card_index, card_valid, done;
//                      receives card_ready.
//   slave  (dealer)  : the mirror image.
//   A card moves on any cycle where card_valid and card_ready are both high.
interface deck_shuffler_if #(
  parameter int CARD_SIZE = 7
);
  logic [CARD_SIZE-1:0] card_out;
  logic [5:0]           card_index;
  logic                 card_valid;
  logic                 card_ready;
  logic                 done;

  modport master (
    output card_out,
    output card_index,
    output card_valid,
    output done,
    input  card_ready
  );

  modport slave (
    input  card_out,
    input  card_index,
    input  card_valid,
    input  done,
    output card_ready
  );
endinterface

// File: rtl/deck_shuffler.sv
// deck_shuffler
//   Builds an ordered 52-card deck, scrambles it in place with a
//   Fisher-Yates shuffle driven by a seedable 16-bit Galois LFSR, then
//   streams the cards to the setup dealer one per handshake.
//   Card word: [6:3] rank 1..13, [2:1] suit (heart, club, diamond, spade),
//   [0] visibility, always 0 here so every card leaves face down.
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   seed_load  in IDLE, load seed into the LFSR (zero seed -> LFSR_SEED)
//   seed       16-bit seed value
//   start      in IDLE, begin init + shuffle + stream
//   busy       high in every state except IDLE
//   bus        card stream (card_out, card_index, card_valid, card_ready, done)
module deck_shuffler #(
  parameter int          CARD_SIZE = 7,
  parameter int          DECK_SIZE = 52,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  input  logic            start,
  output logic            busy,
  deck_shuffler_if.master bus
);

  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, STREAM} state_t;

  localparam logic [5:0]  LAST_IDX = 6'(DECK_SIZE - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t               state;
  state_t               state_next;
  logic [CARD_SIZE-1:0] deck [DECK_SIZE];
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_step;
  logic [5:0]           swap_i;
  logic [5:0]           swap_j;
  logic [5:0]           stream_idx;
  logic                 xfer;
  logic                 last_xfer;
  logic                 done_q;

  // Scaling the LFSR word by (i+1) and keeping the top bits maps it onto
  // 0..i without a divider; the product needs 22 bits.
  assign swap_j    = 6'(({6'd0, lfsr} * {16'd0, swap_i + 6'd1}) >> 16);
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign xfer      = (state == STREAM) && bus.card_ready;
  assign last_xfer = xfer && (stream_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = SHUFFLE;
      SHUFFLE: if (swap_i == 6'd1) state_next = STREAM;
      STREAM:  if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; card_out is forced to zero outside STREAM so the bus never
  // shows stale deck contents.
  always_comb begin
    busy           = (state != IDLE);
    bus.card_valid = (state == STREAM);
    bus.card_out   = '0;
    if (state == STREAM) bus.card_out = deck[stream_idx];
    bus.card_index = stream_idx;
    bus.done       = done_q;
  end

  // Control datapath: LFSR, shuffle position, stream position, done pulse.
  // The LFSR survives between games so back-to-back starts differ.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      swap_i     <= '0;
      stream_idx <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_xfer;
      unique case (state)
        IDLE: begin
          if (seed_load) lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
        end
        INIT: begin
          swap_i     <= LAST_IDX;
          stream_idx <= '0;
        end
        SHUFFLE: begin
          lfsr   <= lfsr_step;
          swap_i <= swap_i - 6'd1;
        end
        STREAM: begin
          if (last_xfer) stream_idx <= '0;
          else if (xfer) stream_idx <= stream_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Deck storage; contents are meaningless until INIT rewrites them, so it
  // has no reset. When j equals i both writes carry the same card.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int k = 0; k < DECK_SIZE; k++)
        deck[k] <= CARD_SIZE'({4'((k % 13) + 1), 2'(k / 13), 1'b0});
    end else if (state == SHUFFLE) begin
      deck[swap_i] <= deck[swap_j];
      deck[swap_j] <= deck[swap_i];
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// tb_deck_shuffler
//   Drives deck_shuffler through a table of complete games and compares
//   every streamed deck against a reference Fisher-Yates/LFSR model, plus
//   hand-written reset and reproducibility sequences.
module tb_deck_shuffler;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        start;
  logic        busy;

  deck_shuffler_if #(.CARD_SIZE(7)) bus ();

  deck_shuffler #(
    .CARD_SIZE(7),
    .DECK_SIZE(52),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed     (seed),
    .start    (start),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] seed;
    logic        bp;
    logic        perturb;
    logic        chk_last;
    logic [6:0]  exp_last;
    int          exp_latency;
    int          exp_xfers;
  } game_vec_t;

  game_vec_t  vecs [7];
  logic [6:0] run_seq [7][52];
  logic [6:0] got_seq [52];
  logic [6:0] exp_seq [52];
  logic [15:0] model_lfsr;

  int total;
  int passed;

  int r_latency, r_xfers, r_done_cnt, r_done_off, r_busy_at_done;
  int r_idx_err, r_stall_err, r_last_cyc, r_done_after;

  // Every comparison funnels through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic st, input logic ld, input logic [15:0] sd);
    start     = st;
    seed_load = ld;
    seed      = sd;
  endtask

  // Reference shuffle, written straight from the algorithm description.
  task automatic modelGame(input logic load, input logic [15:0] sd);
    logic [6:0] d [52];
    logic [6:0] t;
    int j;
    if (load) model_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int k = 0; k < 52; k++) d[k] = {4'((k % 13) + 1), 2'(k / 13), 1'b0};
    for (int i = 51; i >= 1; i--) begin
      j = (int'(model_lfsr) * (i + 1)) / 65536;
      t = d[i]; d[i] = d[j]; d[j] = t;
      model_lfsr = model_lfsr[0] ? ((model_lfsr >> 1) ^ 16'hB400) : (model_lfsr >> 1);
    end
    for (int k = 0; k < 52; k++) exp_seq[k] = d[k];
  endtask

  // Runs one game cycle by cycle; cyc counts cycles after the start edge.
  // abort_after >= 0 stops sampling once that many cards have transferred.
  task automatic runGame(input logic load, input logic [15:0] sd, input logic bp,
                         input logic perturb, input int abort_after);
    logic       stalled;
    logic [6:0] held_card;
    logic [5:0] held_idx;
    r_latency = -1; r_xfers = 0; r_done_cnt = 0; r_done_off = -1;
    r_busy_at_done = -1; r_idx_err = 0; r_stall_err = 0; r_last_cyc = -1;
    r_done_after = -1; stalled = 1'b0; held_card = '0; held_idx = '0;
    for (int k = 0; k < 52; k++) got_seq[k] = '0;
    @(posedge clk); #1;
    applyStimulus(1'b1, load, sd);
    bus.card_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    for (int cyc = 1; cyc < 1000; cyc++) begin
      if (perturb && cyc == 10) applyStimulus(1'b1, 1'b1, 16'hFFFF);
      if (perturb && cyc == 11) applyStimulus(1'b0, 1'b0, 16'h0000);
      if (stalled && (bus.card_out !== held_card || bus.card_index !== held_idx))
        r_stall_err++;
      if (bus.done) begin
        r_done_cnt++; r_done_off = cyc; r_busy_at_done = int'(busy);
        break;
      end
      if (abort_after >= 0 && r_xfers == abort_after) break;
      bus.card_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.card_valid && r_latency < 0) r_latency = cyc;
      stalled   = bus.card_valid && !bus.card_ready;
      held_card = bus.card_out;
      held_idx  = bus.card_index;
      if (bus.card_valid && bus.card_ready) begin
        if (bus.card_index != 6'(r_xfers)) r_idx_err++;
        if (r_xfers < 52) got_seq[r_xfers] = bus.card_out;
        r_xfers++;
        r_last_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (r_done_cnt > 0) begin
      @(posedge clk); #1;
      r_done_after = int'(bus.done);
    end
  endtask

  function automatic int permOk();
    logic seen [128];
    int ok;
    ok = 0;
    for (int k = 0; k < 128; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++) begin
      if (got_seq[k][0] == 1'b0 && got_seq[k][6:3] >= 4'd1 && got_seq[k][6:3] <= 4'd13
          && !seen[got_seq[k]]) ok++;
      seen[got_seq[k]] = 1'b1;
    end
    return ok;
  endfunction

  function automatic int diffModel();
    int n;
    n = 0;
    for (int k = 0; k < 52; k++) if (got_seq[k] !== exp_seq[k]) n++;
    return n;
  endfunction

  function automatic int diffRuns(input int a, input int b);
    int n;
    n = 0;
    for (int k = 0; k < 52; k++) if (run_seq[a][k] !== run_seq[b][k]) n++;
    return n;
  endfunction

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    bus.card_ready = 1'b0;
    model_lfsr = 16'hACE1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(bus.card_valid), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_card_out", int'(bus.card_out), 0);
    checkOutput("reset_card_index", int'(bus.card_index), 0);
    rst = 1'b0;

    // Last dealt card is hand-derived from the first swap (i=51).
    //                load  seed      bp    pert  chk   last   lat xfers
    vecs[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 7'h08, 53, 52};
    vecs[1] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 7'h20, 53, 52};
    vecs[2] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 7'h20, 53, 52};
    vecs[3] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 7'h54, 53, 52};
    vecs[4] = '{1'b1, 16'hACE1, 1'b0, 1'b0, 1'b1, 7'h54, 53, 52};
    vecs[5] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 7'h08, 53, 52};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'h00, 53, 52};

    for (int v = 0; v < 7; v++) begin
      modelGame(vecs[v].load, vecs[v].seed);
      runGame(vecs[v].load, vecs[v].seed, vecs[v].bp, vecs[v].perturb, -1);
      $display("[TB] game %0d seed %h bp %0d perturb %0d", v, vecs[v].seed,
               vecs[v].bp, vecs[v].perturb);
      checkOutput($sformatf("g%0d_latency", v), r_latency, vecs[v].exp_latency);
      checkOutput($sformatf("g%0d_xfers", v), r_xfers, vecs[v].exp_xfers);
      checkOutput($sformatf("g%0d_index_order", v), r_idx_err, 0);
      checkOutput($sformatf("g%0d_done_count", v), r_done_cnt, 1);
      checkOutput($sformatf("g%0d_done_cycle", v), r_done_off,
                  vecs[v].bp ? r_last_cyc + 1 : 105);
      checkOutput($sformatf("g%0d_done_single", v), r_done_after, 0);
      checkOutput($sformatf("g%0d_busy_at_done", v), r_busy_at_done, 0);
      checkOutput($sformatf("g%0d_permutation", v), permOk(), 52);
      checkOutput($sformatf("g%0d_vs_model", v), diffModel(), 0);
      if (vecs[v].bp) checkOutput($sformatf("g%0d_stall_hold", v), r_stall_err, 0);
      if (vecs[v].chk_last)
        checkOutput($sformatf("g%0d_last_card", v), int'(got_seq[51]), int'(vecs[v].exp_last));
      for (int k = 0; k < 52; k++) run_seq[v][k] = got_seq[k];
    end

    // Reproducibility, zero-seed substitution, busy ignores, no reseed.
    checkOutput("repro_1234", diffRuns(1, 2), 0);
    checkOutput("zero_seed_eq_ace1", diffRuns(3, 4), 0);
    checkOutput("busy_ignores_inputs", diffRuns(5, 0), 0);
    checkOutput("no_reseed_differs", int'(diffRuns(6, 5) != 0), 1);

    // Reset after card 20 has transferred abandons the stream.
    runGame(1'b1, 16'h0001, 1'b0, 1'b0, 21);
    checkOutput("abort_xfers", r_xfers, 21);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_valid", int'(bus.card_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_card_index", int'(bus.card_index), 0);
    checkOutput("abort_card_out", int'(bus.card_out), 0);
    rst = 1'b0;
    model_lfsr = 16'hACE1;

    modelGame(1'b1, 16'h0001);
    runGame(1'b1, 16'h0001, 1'b0, 1'b0, -1);
    checkOutput("post_abort_xfers", r_xfers, 52);
    checkOutput("post_abort_vs_model", diffModel(), 0);
    for (int k = 0; k < 52; k++) run_seq[6][k] = got_seq[k];
    checkOutput("post_abort_vs_first", diffRuns(6, 0), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
